// File: rtl/ball_physics_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : ball_physics_engine_if
// Purpose  : Frame-tick controls in, ball/brick/game status out.
// Revision : 1.0  initial release
// ============================================================================
interface ball_physics_engine_if;
  logic        tick;
  logic        start;
  logic [9:0]  paddle_x;
  logic [9:0]  ball_x;
  logic [9:0]  ball_y;
  logic [59:0] brick_alive;
  logic        hit_valid;
  logic [5:0]  hit_idx;
  logic        lost;
  logic [1:0]  lives;
  logic [5:0]  score;
  logic [2:0]  state;

  modport master (
    output tick, start, paddle_x,
    input  ball_x, ball_y, brick_alive, hit_valid, hit_idx, lost, lives, score, state
  );

  modport slave (
    input  tick, start, paddle_x,
    output ball_x, ball_y, brick_alive, hit_valid, hit_idx, lost, lives, score, state
  );
endinterface
`default_nettype wire

// File: rtl/ball_physics_engine.sv
`default_nettype none
// ============================================================================
// Module   : ball_physics_engine
// Purpose  : Per-frame ball motion, wall/ceiling/paddle reflection, brick hits.
// Revision : 1.0  initial release
// ============================================================================
module ball_physics_engine #(
  parameter int unsigned LEFT_WALL_X   = 190,
  parameter int unsigned RIGHT_WALL_X  = 790,
  parameter int unsigned CEILING_Y     = 35,
  parameter int unsigned FLOOR_Y       = 515,
  parameter int unsigned GRID_BOTTOM_Y = 160,
  parameter int unsigned BLOCK_W       = 50,
  parameter int unsigned BLOCK_H       = 25,
  parameter int unsigned BALL_HALF     = 5,
  parameter int unsigned PADDLE_Y      = 500,
  parameter int unsigned PADDLE_HALF_W = 25,
  parameter int unsigned SPEED         = 2,
  parameter int unsigned LIVES         = 3
) (
  input wire                    clk,
  input wire                    rst,
  ball_physics_engine_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MOVE  = 3'd1,
    S_CHECK = 3'd2,
    S_LOST  = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } state_t;

  localparam int unsigned c_ROWS = 5;
  localparam int unsigned c_COLS = 12;

  // Edge conditions folded onto the ball centre so no subtraction can wrap.
  localparam logic [9:0] c_SPEED      = 10'(SPEED);
  localparam logic [9:0] c_HALF       = 10'(BALL_HALF);
  localparam logic [9:0] c_RIGHT_LIM  = 10'(RIGHT_WALL_X - BALL_HALF);
  localparam logic [9:0] c_LEFT_LIM   = 10'(LEFT_WALL_X + BALL_HALF);
  localparam logic [9:0] c_CEIL_LIM   = 10'(CEILING_Y + BALL_HALF);
  localparam logic [9:0] c_PAD_LIM    = 10'(PADDLE_Y - 5 - BALL_HALF);
  localparam logic [9:0] c_PAD_REACH  = 10'(PADDLE_HALF_W + BALL_HALF);
  localparam logic [9:0] c_FLOOR_LIM  = 10'(FLOOR_Y - BALL_HALF);
  localparam logic [9:0] c_REST_Y     = 10'(PADDLE_Y - 10);
  localparam logic [9:0] c_RESET_X    = 10'd450;
  localparam logic [9:0] c_GRID_L     = 10'(LEFT_WALL_X);
  localparam logic [9:0] c_GRID_R     = 10'(RIGHT_WALL_X);
  localparam logic [9:0] c_GRID_T     = 10'(CEILING_Y);
  localparam logic [9:0] c_GRID_B     = 10'(GRID_BOTTOM_Y);
  localparam logic [1:0] c_LIVES      = 2'(LIVES);

  state_t      r_state;
  state_t      w_state_next;
  logic [9:0]  r_ball_x;
  logic [9:0]  r_ball_y;
  logic [9:0]  r_nx;
  logic [9:0]  r_ny;
  logic        r_dx;          // 1 = moving right
  logic        r_dy;          // 1 = moving down
  logic [59:0] r_brick_alive;
  logic        r_hit_valid;
  logic [5:0]  r_hit_idx;
  logic        r_lost;
  logic [1:0]  r_lives;
  logic [5:0]  r_score;

  logic [9:0]  w_sx;
  logic [9:0]  w_sy;
  logic [9:0]  w_nx;
  logic [9:0]  w_ny;
  logic        w_ndx;
  logic        w_ndy;
  logic [9:0]  w_pad_dist;
  logic        w_floor;

  logic [9:0]  w_px;
  logic [9:0]  w_py;
  logic        w_in_grid;
  logic [2:0]  w_row;
  logic [3:0]  w_col;
  logic [5:0]  w_idx;
  logic        w_hit;
  logic [59:0] w_alive_next;

  // Candidate next position with wall, ceiling and paddle rules applied in order.
  always_comb begin
    w_sx  = r_dx ? (r_ball_x + c_SPEED) : (r_ball_x - c_SPEED);
    w_sy  = r_dy ? (r_ball_y + c_SPEED) : (r_ball_y - c_SPEED);
    w_nx  = w_sx;
    w_ny  = w_sy;
    w_ndx = r_dx;
    w_ndy = r_dy;

    if (r_dx && (w_sx >= c_RIGHT_LIM)) begin
      w_nx  = c_RIGHT_LIM;
      w_ndx = 1'b0;
    end else if (!r_dx && (w_sx <= c_LEFT_LIM)) begin
      w_nx  = c_LEFT_LIM;
      w_ndx = 1'b1;
    end

    if (!r_dy && (w_sy <= c_CEIL_LIM)) begin
      w_ny  = c_CEIL_LIM;
      w_ndy = 1'b1;
    end

    w_pad_dist = (w_nx >= bus.paddle_x) ? (w_nx - bus.paddle_x) : (bus.paddle_x - w_nx);
    if (r_dy && (r_ball_y < c_PAD_LIM) && (w_ny >= c_PAD_LIM) && (w_pad_dist <= c_PAD_REACH)) begin
      w_ny  = c_PAD_LIM;
      w_ndy = 1'b0;
      w_ndx = (w_nx >= bus.paddle_x);
    end

    w_floor = (w_ny >= c_FLOOR_LIM);
  end

  // Leading-edge probe into the brick grid; row/col found by threshold compares.
  always_comb begin
    w_px      = r_nx;
    w_py      = r_dy ? (r_ny + c_HALF) : (r_ny - c_HALF);
    w_in_grid = (w_py >= c_GRID_T) && (w_py < c_GRID_B) && (w_px >= c_GRID_L) && (w_px < c_GRID_R);

    w_row = 3'd0;
    for (int k = 1; k < c_ROWS; k++) begin
      if (w_py >= 10'(CEILING_Y + k * BLOCK_H)) w_row = w_row + 3'd1;
    end

    w_col = 4'd0;
    for (int k = 1; k < c_COLS; k++) begin
      if (w_px >= 10'(LEFT_WALL_X + k * BLOCK_W)) w_col = w_col + 4'd1;
    end

    w_idx        = ({3'd0, w_row} * 6'(c_COLS)) + {2'd0, w_col};
    w_hit        = w_in_grid && r_brick_alive[w_idx];
    w_alive_next = r_brick_alive & ~(w_hit ? (60'd1 << w_idx) : 60'd0);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_MOVE;
      S_MOVE:  if (bus.tick)  w_state_next = w_floor ? S_LOST : S_CHECK;
      S_CHECK: w_state_next = (w_alive_next == '0) ? S_WIN : S_MOVE;
      S_LOST:  w_state_next = (r_lives == 2'd1) ? S_OVER : S_IDLE;
      default: w_state_next = r_state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ball_x      <= c_RESET_X;
      r_ball_y      <= c_REST_Y;
      r_nx          <= c_RESET_X;
      r_ny          <= c_REST_Y;
      r_dx          <= 1'b1;
      r_dy          <= 1'b0;
      r_brick_alive <= '1;
      r_hit_valid   <= 1'b0;
      r_hit_idx     <= 6'd0;
      r_lost        <= 1'b0;
      r_lives       <= c_LIVES;
      r_score       <= 6'd0;
    end else begin
      r_hit_valid <= 1'b0;
      r_lost      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ball_x <= bus.paddle_x;
          r_ball_y <= c_REST_Y;
          if (bus.start) begin
            r_dx <= 1'b1;
            r_dy <= 1'b0;
          end
        end
        S_MOVE: begin
          if (bus.tick) begin
            r_nx <= w_nx;
            r_ny <= w_ny;
            r_dx <= w_ndx;
            r_dy <= w_ndy;
          end
        end
        S_CHECK: begin
          r_ball_x <= r_nx;
          r_ball_y <= r_ny;
          if (w_hit) begin
            r_brick_alive <= w_alive_next;
            r_dy          <= ~r_dy;
            r_hit_valid   <= 1'b1;
            r_hit_idx     <= w_idx;
            r_score       <= r_score + 6'd1;
          end
        end
        S_LOST: begin
          r_lost  <= 1'b1;
          r_lives <= r_lives - 2'd1;
          r_dx    <= 1'b1;
          r_dy    <= 1'b0;
        end
        default: begin
          r_lost <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ball_x      = r_ball_x;
  assign bus.ball_y      = r_ball_y;
  assign bus.brick_alive = r_brick_alive;
  assign bus.hit_valid   = r_hit_valid;
  assign bus.hit_idx     = r_hit_idx;
  assign bus.lost        = r_lost;
  assign bus.lives       = r_lives;
  assign bus.score       = r_score;
  assign bus.state       = r_state;

endmodule
`default_nettype wire
